// File: rtl/jt900h_shift_seq_pkg.sv
// Shared constants and types for the multi-bit shift/rotate sequencer.
// ALU select and carry-source codes mirror the 900H parameter set.
package jt900h_shift_seq_pkg;

   localparam logic [4:0] SHL_ALU = 5'd10;
   localparam logic [4:0] SHR_ALU = 5'd11;

   localparam logic [2:0] CIN_CX  = 3'd1;
   localparam logic [2:0] SA_CX   = 3'd2;
   localparam logic [2:0] SH_CX   = 3'd3;
   // Unused carry-source code: the ALU falls back to cx=0
   localparam logic [2:0] ZERO_CX = 3'd7;

   typedef enum logic [2:0] {
      SHOP_RLC = 3'd0,
      SHOP_RRC = 3'd1,
      SHOP_RL  = 3'd2,
      SHOP_RR  = 3'd3,
      SHOP_SLA = 3'd4,
      SHOP_SRA = 3'd5,
      SHOP_SLL = 3'd6,
      SHOP_SRL = 3'd7
   } shop_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [4:0] sel;
      logic [2:0] cx;
   } step_ctl_t;

   function automatic step_ctl_t step_ctl(input shop_e op);
      step_ctl_t c;
      c = '0;
      case (op)
         SHOP_RLC: c = '{sel: SHL_ALU, cx: SA_CX};
         SHOP_RRC: c = '{sel: SHR_ALU, cx: SH_CX};
         SHOP_RL:  c = '{sel: SHL_ALU, cx: CIN_CX};
         SHOP_RR:  c = '{sel: SHR_ALU, cx: CIN_CX};
         SHOP_SLA: c = '{sel: SHL_ALU, cx: ZERO_CX};
         SHOP_SRA: c = '{sel: SHR_ALU, cx: SA_CX};
         SHOP_SLL: c = '{sel: SHL_ALU, cx: ZERO_CX};
         SHOP_SRL: c = '{sel: SHR_ALU, cx: ZERO_CX};
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/jt900h_shift_seq_if.sv
// Bundle between the control unit / shared ALU (master) and the shift sequencer (slave).
// alu_w carries the latched operand width {qs,ws,bs} towards the ALU.
interface jt900h_shift_seq_if;
   logic        start;
   logic [2:0]  sh_op;
   logic        bs;
   logic        ws;
   logic        qs;
   logic [4:0]  cnt;
   logic [31:0] din;
   logic        cin;
   logic        busy;
   logic        done;
   logic [31:0] dout;
   logic        cout;

   logic [4:0]  alu_sel;
   logic [2:0]  cx_sel;
   logic [31:0] alu_op2;
   logic        alu_cin;
   logic [2:0]  alu_w;
   logic [31:0] alu_rslt;
   logic        alu_c;

   modport master (
      output start, sh_op, bs, ws, qs, cnt, din, cin, alu_rslt, alu_c,
      input  busy, done, dout, cout, alu_sel, cx_sel, alu_op2, alu_cin, alu_w
   );

   modport slave (
      input  start, sh_op, bs, ws, qs, cnt, din, cin, alu_rslt, alu_c,
      output busy, done, dout, cout, alu_sel, cx_sel, alu_op2, alu_cin, alu_w
   );
endinterface

// File: rtl/jt900h_shift_seq.sv
// Multi-bit shift/rotate sequencer: iterates the ALU's one-bit SHL/SHR step N times,
// holding the running operand and carry between steps.
module jt900h_shift_seq
   import jt900h_shift_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cen,
   jt900h_shift_seq_if.slave    bus
);

   state_e      state_q, state_d;
   logic [31:0] op2_q,   op2_d;
   logic        carry_q, carry_d;
   logic [4:0]  rem_q,   rem_d;
   shop_e       op_q,    op_d;
   logic [2:0]  width_q, width_d;
   logic [31:0] dout_q,  dout_d;
   logic        cout_q,  cout_d;
   step_ctl_t   ctl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op2_q   <= '0;
         carry_q <= 1'b0;
         rem_q   <= '0;
         op_q    <= SHOP_RLC;
         width_q <= '0;
         dout_q  <= '0;
         cout_q  <= 1'b0;
      end else if (cen) begin
         state_q <= state_d;
         op2_q   <= op2_d;
         carry_q <= carry_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         width_q <= width_d;
         dout_q  <= dout_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op2_d   = op2_q;
      carry_d = carry_q;
      rem_d   = rem_q;
      op_d    = op_q;
      width_d = width_q;
      dout_d  = dout_q;
      cout_d  = cout_q;
      ctl     = step_ctl(op_q);

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op2_d   = bus.din;
               carry_d = bus.cin;
               rem_d   = (bus.cnt == 5'd0) ? 5'd16 : bus.cnt;
               op_d    = shop_e'(bus.sh_op);
               width_d = {bus.qs, bus.ws, bus.bs};
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            op2_d   = bus.alu_rslt;
            carry_d = bus.alu_c;
            rem_d   = rem_q - 5'd1;
            // Result is captured on the final step so dout/cout are valid while done is high
            if (rem_q == 5'd1) begin
               dout_d  = bus.alu_rslt;
               cout_d  = bus.alu_c;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy    = (state_q == ST_RUN);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.alu_sel = (state_q == ST_RUN) ? ctl.sel : '0;
   assign bus.cx_sel  = (state_q == ST_RUN) ? ctl.cx  : '0;
   assign bus.alu_op2 = op2_q;
   assign bus.alu_cin = carry_q;
   assign bus.alu_w   = width_q;
   assign bus.dout    = dout_q;
   assign bus.cout    = cout_q;

endmodule

// File: tb/tb_jt900h_shift_seq.sv
// Bench for jt900h_shift_seq: stand-in one-bit ALU, arithmetic reference model with a
// per-cycle compare process, and directed vectors with hand-computed results.
module tb_jt900h_shift_seq;
   import jt900h_shift_seq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic cen = 1'b0;

   jt900h_shift_seq_if bus_if();

   jt900h_shift_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (cen),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned wbits(input logic [2:0] w);
      return w[0] ? 8 : (w[1] ? 16 : 32);
   endfunction

   function automatic logic [31:0] wmask(input logic [2:0] w);
      return w[0] ? 32'h0000_00FF : (w[1] ? 32'h0000_FFFF : 32'hFFFF_FFFF);
   endfunction

   // ---------------- stand-in ALU (one-bit shift step) ----------------
   logic [31:0] alu_mask;
   logic        alu_msb, alu_cx;
   always_comb begin
      alu_mask = wmask(bus_if.alu_w);
      alu_msb  = bus_if.alu_op2[wbits(bus_if.alu_w) - 1];
      case (bus_if.cx_sel)
         SA_CX:   alu_cx = alu_msb;
         SH_CX:   alu_cx = bus_if.alu_op2[0];
         CIN_CX:  alu_cx = bus_if.alu_cin;
         default: alu_cx = 1'b0;
      endcase
      bus_if.alu_rslt = '0;
      bus_if.alu_c    = 1'b0;
      if (bus_if.alu_sel == SHL_ALU) begin
         bus_if.alu_rslt = {bus_if.alu_op2[30:0], alu_cx} & alu_mask;
         bus_if.alu_c    = alu_msb;
      end else if (bus_if.alu_sel == SHR_ALU) begin
         bus_if.alu_rslt = ((bus_if.alu_op2 & alu_mask) >> 1) |
                           ({31'd0, alu_cx} << (wbits(bus_if.alu_w) - 1));
         bus_if.alu_c    = bus_if.alu_op2[0];
      end
   end

   // ---------------- reference: whole N-bit shift in one go ----------------
   function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned k,
                                        input int unsigned len);
      logic [63:0] m;
      m = (64'd1 << len) - 64'd1;
      return ((v << k) | (v >> (len - k))) & m;
   endfunction

   function automatic logic [32:0] ref_shift(input shop_e op, input int unsigned w,
                                             input logic [31:0] x, input logic c,
                                             input int unsigned n);
      logic [63:0] m, v, sx, r, t, cv;
      logic rc;
      m  = (64'd1 << w) - 64'd1;
      v  = {32'd0, x} & m;
      sx = v[w-1] ? (v | ~m) : v;
      cv = {63'd0, c} << w;
      r  = '0;
      rc = 1'b0;
      case (op)
         SHOP_RLC: begin r = rotl(v, n % w, w); rc = r[0]; end
         SHOP_RRC: begin r = rotl(v, (w - n % w) % w, w); rc = r[w-1]; end
         SHOP_RL:  begin t = rotl(v | cv, n % (w + 1), w + 1); r = t & m; rc = t[w]; end
         SHOP_RR:  begin
            t = rotl(v | cv, (w + 1 - n % (w + 1)) % (w + 1), w + 1); r = t & m; rc = t[w];
         end
         SHOP_SLA, SHOP_SLL: begin
            r = (v << n) & m; t = (v << (n - 1)) >> (w - 1); rc = t[0];
         end
         SHOP_SRA: begin
            r = ($signed(sx) >>> n) & m; t = $signed(sx) >>> (n - 1); rc = t[0];
         end
         SHOP_SRL: begin r = v >> n; t = v >> (n - 1); rc = t[0]; end
         default: begin r = '0; rc = 1'b0; end
      endcase
      return {rc, r[31:0]};
   endfunction

   // ---------------- timing/result model ----------------
   int          m_phase = 0;   // 0 idle, 1 busy, 2 done
   int          m_left = 0;
   logic [32:0] m_res = '0, m_next;
   logic [31:0] m_mask = '1, m_dmask = '1, m_dout = '0;
   logic        m_cout = 1'b0;
   shop_e       m_op = SHOP_RLC;

   always_comb
      m_next = ref_shift(shop_e'(bus_if.sh_op), wbits({bus_if.qs, bus_if.ws, bus_if.bs}),
                         bus_if.din, bus_if.cin,
                         (bus_if.cnt == 5'd0) ? 16 : int'(bus_if.cnt));

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_left  <= 0;
         m_dout  <= '0;
         m_cout  <= 1'b0;
         m_dmask <= '1;
      end else if (cen) begin
         case (m_phase)
            0: if (bus_if.start) begin
               m_phase <= 1;
               m_left  <= (bus_if.cnt == 5'd0) ? 16 : int'(bus_if.cnt);
               m_res   <= m_next;
               m_mask  <= wmask({bus_if.qs, bus_if.ws, bus_if.bs});
               m_op    <= shop_e'(bus_if.sh_op);
            end
            1: begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  m_phase <= 2;
                  m_dout  <= m_res[31:0];
                  m_cout  <= m_res[32];
                  m_dmask <= m_mask;
               end
            end
            default: m_phase <= 0;
         endcase
      end
   end

   function automatic logic [7:0] exp_ctl(input shop_e op);
      case (op)
         SHOP_RLC: return {SHL_ALU, SA_CX};
         SHOP_RRC: return {SHR_ALU, SH_CX};
         SHOP_RL:  return {SHL_ALU, CIN_CX};
         SHOP_RR:  return {SHR_ALU, CIN_CX};
         SHOP_SLA: return {SHL_ALU, ZERO_CX};
         SHOP_SRA: return {SHR_ALU, SA_CX};
         SHOP_SLL: return {SHL_ALU, ZERO_CX};
         default:  return {SHR_ALU, ZERO_CX};
      endcase
   endfunction

   always @(negedge clk) begin
      check("busy", 64'(bus_if.busy), 64'(m_phase == 1));
      check("done", 64'(bus_if.done), 64'(m_phase == 2));
      check("dout", 64'(bus_if.dout & m_dmask), 64'(m_dout));
      check("cout", 64'(bus_if.cout), 64'(m_cout));
      if (m_phase == 1)
         check("alu_ctl", 64'({bus_if.alu_sel, bus_if.cx_sel}), 64'(exp_ctl(m_op)));
      else
         check("alu_ctl_idle", 64'({bus_if.alu_sel, bus_if.cx_sel}), 64'd0);
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      shop_e       op;
      int unsigned w;
      logic [31:0] din;
      logic        cin;
      logic [4:0]  cnt;
      logic [31:0] exp;
      logic        expc;
   } vec_t;

   vec_t vecs[14];

   task automatic run_vec(input int i, input bit tog, input bit poke);
      int  lat, bcnt, n;
      bit  got, c_was;
      vec_t v;
      v = vecs[i];
      n = (v.cnt == 5'd0) ? 16 : int'(v.cnt);
      @(posedge clk); #1;
      bus_if.sh_op = v.op;
      bus_if.bs    = (v.w == 8);
      bus_if.ws    = (v.w == 16);
      bus_if.qs    = (v.w == 32);
      bus_if.cnt   = v.cnt;
      bus_if.din   = v.din;
      bus_if.cin   = v.cin;
      bus_if.start = 1'b1;
      cen          = 1'b1;
      lat = 0; bcnt = 0; got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(posedge clk);
         c_was = cen;
         #1;
         if (c_was) begin
            lat++;
            if (bus_if.busy) bcnt++;
         end
         bus_if.start = poke && (lat == 2 || lat == 3);
         if (bus_if.done) got = 1'b1;
         cen = tog ? ~cen : 1'b1;
      end
      bus_if.start = 1'b0;
      cen = 1'b1;
      check($sformatf("v%0d done_seen", i), 64'(got), 64'd1);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(n + 1));
      check($sformatf("v%0d busy_cycles", i), 64'(bcnt), 64'(n));
      check($sformatf("v%0d dout", i), 64'(bus_if.dout & wmask({v.w == 32, v.w == 16, v.w == 8})),
            64'(v.exp));
      check($sformatf("v%0d cout", i), 64'(bus_if.cout), 64'(v.expc));
   endtask

   initial begin
      vecs[0]  = '{SHOP_RLC,  8, 32'h0000_0081, 1'b0, 5'd1,  32'h0000_0003, 1'b1};
      vecs[1]  = '{SHOP_SRA, 16, 32'h0000_8000, 1'b0, 5'd4,  32'h0000_F800, 1'b0};
      vecs[2]  = '{SHOP_RR,   8, 32'h0000_0001, 1'b0, 5'd1,  32'h0000_0000, 1'b1};
      vecs[3]  = '{SHOP_RL,   8, 32'h0000_0080, 1'b1, 5'd1,  32'h0000_0001, 1'b1};
      vecs[4]  = '{SHOP_RLC, 16, 32'h0000_1234, 1'b0, 5'd0,  32'h0000_1234, 1'b0};
      vecs[5]  = '{SHOP_SLL, 32, 32'h0000_0001, 1'b0, 5'd16, 32'h0001_0000, 1'b0};
      vecs[6]  = '{SHOP_SRA,  8, 32'h0000_0080, 1'b0, 5'd16, 32'h0000_00FF, 1'b1};
      vecs[7]  = '{SHOP_SRL,  8, 32'h0000_0080, 1'b0, 5'd16, 32'h0000_0000, 1'b0};
      vecs[8]  = '{SHOP_RRC,  8, 32'h0000_0001, 1'b0, 5'd3,  32'h0000_0020, 1'b0};
      vecs[9]  = '{SHOP_SLA, 32, 32'hC000_0000, 1'b0, 5'd1,  32'h8000_0000, 1'b1};
      vecs[10] = '{SHOP_RRC, 32, 32'h0000_0001, 1'b0, 5'd16, 32'h0001_0000, 1'b0};
      vecs[11] = '{SHOP_RL,  16, 32'h0000_8000, 1'b0, 5'd16, 32'h0000_4000, 1'b0};
      vecs[12] = '{SHOP_SLA,  8, 32'h0000_0081, 1'b0, 5'd16, 32'h0000_0000, 1'b0};
      vecs[13] = '{SHOP_RR,  32, 32'h8000_0001, 1'b1, 5'd2,  32'hE000_0000, 1'b0};

      bus_if.start = 1'b0; bus_if.sh_op = '0; bus_if.bs = 1'b1; bus_if.ws = 1'b0;
      bus_if.qs = 1'b0; bus_if.cnt = '0; bus_if.din = '0; bus_if.cin = 1'b0;

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 64'(bus_if.busy), 64'd0);
      check("rst done", 64'(bus_if.done), 64'd0);
      check("rst dout", 64'(bus_if.dout), 64'd0);
      check("rst op2",  64'(bus_if.alu_op2), 64'd0);
      check("rst cin",  64'(bus_if.alu_cin), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cen   = 1'b1;

      for (int i = 0; i < 14; i++)
         run_vec(i, i == 4, i == 1);

      // asynchronous reset in the middle of a long shift
      @(posedge clk); #1;
      bus_if.sh_op = SHOP_SLL; bus_if.bs = 1'b0; bus_if.ws = 1'b0; bus_if.qs = 1'b1;
      bus_if.din = 32'h0000_0001; bus_if.cnt = 5'd10; bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst busy", 64'(bus_if.busy), 64'd0);
      check("midrst dout", 64'(bus_if.dout), 64'd0);
      check("midrst cout", 64'(bus_if.cout), 64'd0);
      check("midrst op2",  64'(bus_if.alu_op2), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_vec(0, 1'b0, 1'b0);
      run_vec(13, 1'b1, 1'b0);
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1);
   end

endmodule
